uart_tx_ctrl: RTL and testbench

UART transmit controller that frames and sequences one byte at a time onto the serial line.
- Runs on the 16x oversample clock `baud_clk`.
- Owns an internal bit-period divider, so each serial bit lasts exactly OVERSAMPLE clocks.
- Accepts words through a valid/ready handshake from the LSU-side UART wrapper.
- Drives `tx` and reports busy/done status for the memory-mapped UART registers.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_bit_timer.sv | 51 +++++
 rtl/uart_tx_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART transmit path.
//   tx_state_t : frame sequencing states of the transmit controller
//   DEFAULT_*  : default frame geometry used by the controller parameters
//   parity_bit : parity over a zero-extended payload (even or odd sense)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    // Payloads narrower than 8 bits arrive zero-extended, so the unused
    // upper bits do not disturb the XOR reduction.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Divide-by-OVERSAMPLE bit-period counter for the UART transmitter.
//   baud_clk    : oversample clock
//   reset       : synchronous, active-high reset
//   enable      : count while a frame is in progress
//   clear       : synchronous clear (wins over enable)
//   bit_end     : high for the last clock of each bit period
//   bit_pre_end : high for the clock just before bit_end, so the controller
//                 can register outputs that must line up with bit_end
// -----------------------------------------------------------------------------
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic baud_clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(OVERSAMPLE - 2);

    logic [CNT_W-1:0] count_r;

    // Bit-period counter: wraps explicitly at OVERSAMPLE-1, never by overflow.
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            if (count_r == CNT_LAST) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign bit_end     = enable & ~clear & (count_r == CNT_LAST);
    assign bit_pre_end = enable & ~clear & (count_r == CNT_PRE);

endmodule

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit controller: accepts one payload word through a valid/ready
// handshake and serialises it as start, data (LSB first), optional parity and
// stop bits, each bit lasting OVERSAMPLE clocks.
//   baud_clk : oversample clock, the only clock
//   reset    : synchronous, active-high reset (abandons any frame in flight)
//   tx_data  : payload, sampled only on handshake
//   tx_valid : requester has data
//   tx_ready : idle and able to accept
//   tx       : serial line, idles high
//   tx_busy  : frame in progress
//   tx_done  : one-cycle pulse on the last clock of the final stop bit
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 baud_clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    generate
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
            $error("uart_tx_ctrl: DATA_BITS must be 5..8");
        end
        if (OVERSAMPLE < 2) begin : g_bad_oversample
            $error("uart_tx_ctrl: OVERSAMPLE must be at least 2");
        end
    endgenerate

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             PAR_ODD       = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    tx_state_t            state_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic                 parity_r;
    logic                 tx_r;
    logic                 ready_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 accept_s;
    logic                 timer_en_s;
    logic                 timer_clr_s;
    logic                 bit_end_s;
    logic                 bit_pre_end_s;

    assign accept_s    = tx_valid & ready_r;
    assign timer_en_s  = (state_r != IDLE);
    assign timer_clr_s = (state_r == IDLE);

    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .baud_clk    (baud_clk),
        .reset       (reset),
        .enable      (timer_en_s),
        .clear       (timer_clr_s),
        .bit_end     (bit_end_s),
        .bit_pre_end (bit_pre_end_s)
    );

    // Frame sequencer; tx is updated on the same edge as the state so the
    // line level always matches the state it belongs to.
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            state_r   <= IDLE;
            shift_r   <= {DATA_BITS{1'b0}};
            bit_idx_r <= {IDX_W{1'b0}};
            parity_r  <= 1'b0;
            tx_r      <= 1'b1;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r   <= START;
                        shift_r   <= tx_data;
                        parity_r  <= parity_bit(8'(tx_data), PAR_ODD);
                        bit_idx_r <= {IDX_W{1'b0}};
                        tx_r      <= 1'b0;
                        ready_r   <= 1'b0;
                        busy_r    <= 1'b1;
                    end else begin
                        tx_r    <= 1'b1;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        state_r   <= DATA;
                        bit_idx_r <= {IDX_W{1'b0}};
                        tx_r      <= shift_r[0];
                    end else begin
                        tx_r <= 1'b0;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        shift_r <= shift_r >> 1;
                        if (bit_idx_r == IDX_DATA_LAST) begin
                            bit_idx_r <= {IDX_W{1'b0}};
                            if (PARITY_EN != 0) begin
                                state_r <= PARITY;
                                tx_r    <= parity_r;
                            end else begin
                                state_r <= STOP;
                                tx_r    <= 1'b1;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        tx_r <= tx_r;
                    end
                end
                PARITY: begin
                    if (bit_end_s) begin
                        state_r   <= STOP;
                        bit_idx_r <= {IDX_W{1'b0}};
                        tx_r      <= 1'b1;
                    end else begin
                        tx_r <= parity_r;
                    end
                end
                STOP: begin
                    tx_r <= 1'b1;
                    // Raise done one clock early so the registered pulse
                    // lands on the final clock of the last stop bit.
                    if (bit_pre_end_s && (bit_idx_r == IDX_STOP_LAST)) begin
                        done_r <= 1'b1;
                    end else begin
                        done_r <= 1'b0;
                    end
                    if (bit_end_s) begin
                        if (bit_idx_r == IDX_STOP_LAST) begin
                            state_r   <= IDLE;
                            bit_idx_r <= {IDX_W{1'b0}};
                            ready_r   <= 1'b1;
                            busy_r    <= 1'b0;
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                        end
                    end else begin
                        bit_idx_r <= bit_idx_r;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bit_idx_r <= {IDX_W{1'b0}};
                    tx_r      <= 1'b1;
                    ready_r   <= 1'b1;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign tx       = tx_r;
    assign tx_ready = ready_r;
    assign tx_busy  = busy_r;
    assign tx_done  = done_r;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Self-checking bench for uart_tx_ctrl. Several configurations run side by
// side; a frame model derives each expected line level from the frame layout
// (start, LSB-first data, optional parity, stop bits) using plain arithmetic.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    localparam int NDUT = 5;
    // 0: defaults, 1: even parity, 2: odd parity, 3: two stop bits,
    // 4: narrow/short geometry with odd parity and two stop bits
    localparam int DB [NDUT] = '{8, 8, 8, 8, 5};
    localparam int OS [NDUT] = '{16, 16, 16, 16, 3};
    localparam int SB [NDUT] = '{1, 1, 1, 2, 2};
    localparam int PE [NDUT] = '{0, 1, 1, 0, 1};
    localparam int PO [NDUT] = '{0, 0, 1, 0, 1};

    logic       baud_clk;
    logic       reset;
    logic [7:0] tx_data_a  [NDUT];
    logic       tx_valid_a [NDUT];
    logic       tx_ready_o [NDUT];
    logic       tx_o       [NDUT];
    logic       tx_busy_o  [NDUT];
    logic       tx_done_o  [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uart_tx_ctrl #(
            .DATA_BITS  (DB[g]),
            .OVERSAMPLE (OS[g]),
            .STOP_BITS  (SB[g]),
            .PARITY_EN  (PE[g]),
            .PARITY_ODD (PO[g])
        ) dut (
            .baud_clk (baud_clk),
            .reset    (reset),
            .tx_data  (tx_data_a[g][DB[g]-1:0]),
            .tx_valid (tx_valid_a[g]),
            .tx_ready (tx_ready_o[g]),
            .tx       (tx_o[g]),
            .tx_busy  (tx_busy_o[g]),
            .tx_done  (tx_done_o[g])
        );
    end

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    // Number of bit periods in one frame of configuration k.
    function automatic int nbits(input int k);
        return 1 + DB[k] + PE[k] + SB[k];
    endfunction

    // Expected line level during bit period p of a frame carrying d.
    function automatic logic exp_bit(input int k, input logic [7:0] d, input int p);
        int ones;
        if (p == 0) return 1'b0;
        if (p <= DB[k]) return d[p-1];
        if (PE[k] != 0 && p == DB[k] + 1) begin
            ones = 0;
            for (int i = 0; i < DB[k]; i++) ones += int'(d[i]);
            return ((ones % 2) != PO[k]) ? 1'b1 : 1'b0;
        end
        return 1'b1;
    endfunction

    // Called on a negedge while idle; ends on the negedge of the first tx-low cycle.
    task automatic start_frame(input int k, input logic [7:0] d);
        n_checks++;
        if (tx_ready_o[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before_send dut%0d: tx_ready=%b, required 1", k, tx_ready_o[k]);
        end
        tx_valid_a[k] = 1'b1;
        tx_data_a[k]  = d;
        @(posedge baud_clk);
        @(negedge baud_clk);
        tx_valid_a[k] = 1'b0;
    endtask

    // Starts on the negedge of the first tx-low cycle, ends on the last frame cycle.
    task automatic check_frame(input int k, input logic [7:0] d, input string name);
        int len, bad_tx, first_bad, bad_st, done_n, done_at;
        len = nbits(k) * OS[k];
        bad_tx = 0; first_bad = -1; bad_st = 0; done_n = 0; done_at = -1;
        for (int c = 1; c <= len; c++) begin
            if (c > 1) @(negedge baud_clk);
            if (tx_o[k] !== exp_bit(k, d, (c - 1) / OS[k])) begin
                if (bad_tx == 0) first_bad = c;
                bad_tx++;
            end
            if (tx_busy_o[k] !== 1'b1 || tx_ready_o[k] !== 1'b0) bad_st++;
            if (tx_done_o[k] === 1'b1) begin
                done_n++;
                done_at = c;
            end
        end
        n_checks++;
        if (bad_tx !== 0) begin
            n_fail++;
            $display("FAIL %s_tx dut%0d data=%h: %0d wrong cycles (first at cycle %0d), required 0",
                     name, k, d, bad_tx, first_bad);
        end
        n_checks++;
        if (bad_st !== 0) begin
            n_fail++;
            $display("FAIL %s_busy_ready dut%0d: %0d cycles not busy=1/ready=0, required 0",
                     name, k, bad_st);
        end
        n_checks++;
        if (done_n !== 1 || done_at !== len) begin
            n_fail++;
            $display("FAIL %s_done dut%0d: %0d pulses, last at cycle %0d, required 1 pulse at cycle %0d",
                     name, k, done_n, done_at, len);
        end
    endtask

    // Checks the cycle after a frame (or after reset) is idle: {tx,ready,busy,done}.
    task automatic check_idle(input int k, input string name);
        @(negedge baud_clk);
        n_checks++;
        if ({tx_o[k], tx_ready_o[k], tx_busy_o[k], tx_done_o[k]} !== 4'b1100) begin
            n_fail++;
            $display("FAIL %s_idle dut%0d: {tx,ready,busy,done}=%b, required 1100", name, k,
                     {tx_o[k], tx_ready_o[k], tx_busy_o[k], tx_done_o[k]});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            tx_valid_a[k] = 1'b0;
            tx_data_a[k]  = 8'h00;
        end
        repeat (2) @(posedge baud_clk);
        @(negedge baud_clk);
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if ({tx_o[k], tx_ready_o[k], tx_busy_o[k], tx_done_o[k]} !== 4'b1100) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: {tx,ready,busy,done}=%b, required 1100", k,
                         {tx_o[k], tx_ready_o[k], tx_busy_o[k], tx_done_o[k]});
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_frame();
        start_frame(0, 8'hA5);
        check_frame(0, 8'hA5, "basic_a5");
        check_idle(0, "basic_a5");
    endtask

    task automatic test_parity();
        start_frame(1, 8'h07);
        check_frame(1, 8'h07, "parity_even");
        check_idle(1, "parity_even");
        start_frame(2, 8'h07);
        check_frame(2, 8'h07, "parity_odd");
        check_idle(2, "parity_odd");
    endtask

    task automatic test_back_to_back();
        tx_valid_a[0] = 1'b1;
        tx_data_a[0]  = 8'h55;
        @(posedge baud_clk);
        @(negedge baud_clk);
        tx_data_a[0] = 8'hAA;          // valid stays high; must not disturb frame 1
        check_frame(0, 8'h55, "b2b_first");
        check_idle(0, "b2b_gap");      // exactly one idle-high cycle
        @(negedge baud_clk);           // second frame accepted at the edge before
        tx_valid_a[0] = 1'b0;
        check_frame(0, 8'hAA, "b2b_second");
        check_idle(0, "b2b_second");
    endtask

    task automatic test_busy_ignore();
        int stray;
        start_frame(0, 8'h12);
        fork
            check_frame(0, 8'h12, "busy_ignore");
            begin
                repeat (50) @(negedge baud_clk);
                tx_valid_a[0] = 1'b1;
                tx_data_a[0]  = 8'hFF;
                repeat (3) @(negedge baud_clk);
                tx_valid_a[0] = 1'b0;
            end
        join
        check_idle(0, "busy_ignore");
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge baud_clk);
            if (tx_o[0] !== 1'b1 || tx_busy_o[0] !== 1'b0 || tx_done_o[0] !== 1'b0) stray++;
        end
        n_checks++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL busy_ignore_no_second_frame: %0d non-idle cycles, required 0", stray);
        end
    endtask

    task automatic test_reset_mid_frame();
        int done_seen;
        done_seen = 0;
        start_frame(0, 8'hC3);
        for (int c = 1; c < 40; c++) begin
            if (tx_done_o[0] === 1'b1) done_seen++;
            @(negedge baud_clk);
        end
        if (tx_done_o[0] === 1'b1) done_seen++;
        reset = 1'b1;
        check_idle(0, "reset_mid_frame");
        if (tx_done_o[0] === 1'b1) done_seen++;
        reset = 1'b0;
        n_checks++;
        if (done_seen !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_frame_done: %0d tx_done pulses, required 0", done_seen);
        end
        start_frame(0, 8'h3C);
        check_frame(0, 8'h3C, "after_reset_3c");
        check_idle(0, "after_reset_3c");
    endtask

    task automatic test_two_stop_bits();
        start_frame(3, 8'h00);
        check_frame(3, 8'h00, "stop2_00");
        check_idle(3, "stop2_00");
    endtask

    task automatic test_random();
        logic [7:0] d;
        int gap;
        for (int k = 0; k < NDUT; k++) begin
            for (int n = 0; n < 4; n++) begin
                d   = 8'($urandom_range(0, (1 << DB[k]) - 1));
                gap = $urandom_range(0, 2);
                repeat (gap) @(negedge baud_clk);
                start_frame(k, d);
                check_frame(k, d, "random");
                check_idle(k, "random");
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_frame();
        test_two_stop_bits();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
